// File: rtl/frame_write_sequencer_if.sv
// Pixel stream handshake between the HDMI pixel packer (master) and the
// frame write sequencer (slave).
//   I_pix_data  : pixel word
//   I_pix_valid : word valid
//   I_pix_sof   : first word of a frame, qualified by valid
//   O_pix_ready : word accepted when valid & ready
interface frame_write_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] I_pix_data;
  logic                  I_pix_valid;
  logic                  I_pix_sof;
  logic                  O_pix_ready;

  modport master (
    output I_pix_data,
    output I_pix_valid,
    output I_pix_sof,
    input  O_pix_ready
  );

  modport slave (
    input  I_pix_data,
    input  I_pix_valid,
    input  I_pix_sof,
    output O_pix_ready
  );
endinterface

// File: rtl/frame_write_sequencer.sv
// Write-side controller for the double frame buffer. Gathers one 32-bit
// pixel word per RAM block, then writes all blocks in a single cycle at a
// common address. After a full frame it pulses the buffer swap.
// Optional feature macro: SWAP_GATE_EN (gate the swap on a synchronised
// I_swap_allow; otherwise I_swap_allow is ignored).
// Ports:
//   I_clka, I_rst_n  : write clock, async active-low reset
//   pix (slave)      : pixel stream (data/valid/sof in, ready out)
//   I_swap_allow     : reader idle at frame boundary
//   O_write_enable   : 1-cycle write strobe
//   O_ada_flat       : write address replicated per block
//   O_din_flat       : staged words, field k = block k
//   O_swap_trigger   : 1-cycle swap pulse
//   O_frame_count    : completed frames (wraps)
//   O_sof_error      : 1-cycle pulse on early or missing SOF
module frame_write_sequencer #(
  parameter  int unsigned BYTES_PER_BLOCK = 2250,
  parameter  int unsigned BANK_COUNT      = 6,
  parameter  int unsigned BLOCK_COUNT     = 2,
  parameter  int unsigned DATA_WIDTH_A    = 32,
  localparam int unsigned NUM_BLK         = BANK_COUNT * BLOCK_COUNT,
  localparam int unsigned WORDS_PER_BLK   = (BYTES_PER_BLOCK * 8) / DATA_WIDTH_A,
  localparam int unsigned ADDR_W          = (WORDS_PER_BLK > 1) ? $clog2(WORDS_PER_BLK) : 1
) (
  input  logic                             I_clka,
  input  logic                             I_rst_n,
  frame_write_sequencer_if.slave           pix,
  input  logic                             I_swap_allow,
  output logic                             O_write_enable,
  output logic [NUM_BLK*ADDR_W-1:0]        O_ada_flat,
  output logic [NUM_BLK*DATA_WIDTH_A-1:0]  O_din_flat,
  output logic                             O_swap_trigger,
  output logic [15:0]                      O_frame_count,
  output logic                             O_sof_error
);

  localparam int unsigned SLOT_W   = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1;
  localparam int unsigned STAGE_W  = NUM_BLK * DATA_WIDTH_A;
  localparam int unsigned FC_W     = 16;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_GATHER    = 3'd1;
  localparam logic [2:0] S_WRITE     = 3'd2;
  localparam logic [2:0] S_SWAP_WAIT = 3'd3;
  localparam logic [2:0] S_SWAP      = 3'd4;

  logic [2:0]                  state_q,  state_d;
  logic [SLOT_W-1:0]           slot_q,   slot_d;
  logic [ADDR_W-1:0]           addr_q,   addr_d;
  logic [STAGE_W-1:0]          stage_q,  stage_d;
  logic                        ready_q,  ready_d;
  logic                        we_q,     we_d;
  logic [NUM_BLK*ADDR_W-1:0]   ada_q,    ada_d;
  logic [STAGE_W-1:0]          din_q,    din_d;
  logic                        swap_q,   swap_d;
  logic [FC_W-1:0]             fc_q,     fc_d;
  logic                        err_q,    err_d;
  logic                        accept_c;
  logic [SLOT_W-1:0]           fill_idx_c;
  logic                        swap_ok_c;

`ifdef SWAP_GATE_EN
  // Two-flop synchroniser for the reader-idle indication.
  logic [1:0] allow_sync_q;
  always_ff @(posedge I_clka or negedge I_rst_n) begin
    if (!I_rst_n) allow_sync_q <= 2'b00;
    else          allow_sync_q <= {allow_sync_q[0], I_swap_allow};
  end
  assign swap_ok_c = allow_sync_q[1];
`else
  logic swap_allow_unused;
  assign swap_allow_unused = I_swap_allow;
  assign swap_ok_c         = 1'b1;
`endif

  assign accept_c = pix.I_pix_valid & ready_q;
  // SOF always restarts filling at slot 0.
  assign fill_idx_c = pix.I_pix_sof ? '0 : slot_q;

  // State and datapath registers.
  always_ff @(posedge I_clka or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q <= S_IDLE;
      slot_q  <= '0;
      addr_q  <= '0;
      stage_q <= '0;
      ready_q <= 1'b1;
      we_q    <= 1'b0;
      ada_q   <= '0;
      din_q   <= '0;
      swap_q  <= 1'b0;
      fc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      addr_q  <= addr_d;
      stage_q <= stage_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      ada_q   <= ada_d;
      din_q   <= din_d;
      swap_q  <= swap_d;
      fc_q    <= fc_d;
      err_q   <= err_d;
    end
  end

  // Next-state and next-output logic; outputs are registered from state_d.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    addr_d  = addr_q;
    stage_d = stage_q;
    fc_d    = fc_q;
    err_d   = 1'b0;
    ada_d   = ada_q;
    din_d   = din_q;

    case (state_q)
      S_IDLE, S_GATHER: begin
        if (accept_c) begin
          if ((state_q == S_IDLE) && !pix.I_pix_sof) begin
            err_d = 1'b1;
          end else begin
            if ((state_q == S_GATHER) && pix.I_pix_sof) begin
              err_d  = 1'b1;
              addr_d = '0;
            end
            stage_d[32'(fill_idx_c) * DATA_WIDTH_A +: DATA_WIDTH_A] = pix.I_pix_data;
            if (fill_idx_c == SLOT_W'(NUM_BLK - 1)) begin
              slot_d  = '0;
              state_d = S_WRITE;
            end else begin
              slot_d  = fill_idx_c + SLOT_W'(1);
              state_d = S_GATHER;
            end
          end
        end
      end
      S_WRITE: begin
        if (addr_q == ADDR_W'(WORDS_PER_BLK - 1)) begin
          state_d = S_SWAP_WAIT;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_GATHER;
        end
      end
      S_SWAP_WAIT: begin
        if (swap_ok_c) state_d = S_SWAP;
      end
      S_SWAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d == S_WRITE) begin
      ada_d = {NUM_BLK{addr_d}};
      din_d = stage_d;
    end
    if ((state_d == S_SWAP) && (state_q != S_SWAP)) begin
      fc_d   = fc_q + FC_W'(1);
      addr_d = '0;
    end

    ready_d = (state_d == S_IDLE) || (state_d == S_GATHER);
    we_d    = (state_d == S_WRITE);
    swap_d  = (state_d == S_SWAP);
  end

  assign pix.O_pix_ready = ready_q;
  assign O_write_enable  = we_q;
  assign O_ada_flat      = ada_q;
  assign O_din_flat      = din_q;
  assign O_swap_trigger  = swap_q;
  assign O_frame_count   = fc_q;
  assign O_sof_error     = err_q;

endmodule

// File: tb/tb_frame_write_sequencer.sv
module tb_frame_write_sequencer;

  localparam int unsigned NUM_BLK = 2;
  localparam int unsigned ADDR_W  = 1;
  localparam int unsigned DW      = 32;

  localparam int K_WE   = 0;
  localparam int K_SWAP = 1;
  localparam int K_ERR  = 2;

  typedef struct {
    int          kind;
    logic [1:0]  ada;
    logic [63:0] din;
    logic [15:0] fc;
  } exp_t;

  logic        I_clka;
  logic        I_rst_n;
  logic        I_swap_allow;
  logic        O_write_enable;
  logic [1:0]  O_ada_flat;
  logic [63:0] O_din_flat;
  logic        O_swap_trigger;
  logic [15:0] O_frame_count;
  logic        O_sof_error;

  frame_write_sequencer_if #(.DATA_WIDTH(DW)) pif ();

  frame_write_sequencer #(
    .BYTES_PER_BLOCK(8),
    .BANK_COUNT     (1),
    .BLOCK_COUNT    (2),
    .DATA_WIDTH_A   (32)
  ) dut (
    .I_clka        (I_clka),
    .I_rst_n       (I_rst_n),
    .pix           (pif),
    .I_swap_allow  (I_swap_allow),
    .O_write_enable(O_write_enable),
    .O_ada_flat    (O_ada_flat),
    .O_din_flat    (O_din_flat),
    .O_swap_trigger(O_swap_trigger),
    .O_frame_count (O_frame_count),
    .O_sof_error   (O_sof_error)
  );

  initial I_clka = 1'b0;
  always #5 I_clka = ~I_clka;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   last_we_cyc = 0;
  int   gate_ref_cyc = 0;
  bit   gate_mode = 1'b0;
  int   exp_fc = 0;
  exp_t q[$];

  always @(posedge I_clka) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input logic [1:0] ada, input logic [63:0] din);
    exp_t e;
    e.kind = kind;
    e.ada  = ada;
    e.din  = din;
    e.fc   = '0;
    if (kind == K_SWAP) begin
      exp_fc++;
      e.fc = 16'(exp_fc);
    end
    q.push_back(e);
  endtask

  task automatic pop_check(input int kind);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", kind, cyc);
    end else begin
      e = q.pop_front();
      chk("event_kind", 64'(kind), 64'(e.kind));
      if (kind == K_WE && e.kind == K_WE) begin
        chk("write_ada", 64'(O_ada_flat), 64'(e.ada));
        chk("write_din", O_din_flat, e.din);
      end
      if (kind == K_SWAP && e.kind == K_SWAP) begin
        chk("swap_frame_count", 64'(O_frame_count), 64'(e.fc));
        if (gate_mode) chk("swap_gap_allow", 64'(cyc - gate_ref_cyc), 64'd3);
        else           chk("swap_gap_write", 64'(cyc - last_we_cyc), 64'd2);
      end
    end
  endtask

  // Monitor: pops and compares whenever the DUT presents an event.
  always @(negedge I_clka) begin
    if (I_rst_n) begin
      if (O_sof_error)    pop_check(K_ERR);
      if (O_write_enable) begin
        pop_check(K_WE);
        last_we_cyc = cyc;
      end
      if (O_swap_trigger) pop_check(K_SWAP);
    end
  end

  task automatic send(input logic [31:0] d, input logic s);
    int n;
    pif.I_pix_data  = d;
    pif.I_pix_sof   = s;
    pif.I_pix_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge I_clka);
      if (pif.O_pix_ready) break;
      n++;
      if (n > 60) begin
        checks++;
        failures++;
        $display("FAIL send_timeout: ready stayed 0 for word %0h", d);
        break;
      end
    end
    @(posedge I_clka);
    #1;
    pif.I_pix_valid = 1'b0;
    pif.I_pix_sof   = 1'b0;
  endtask

  task automatic gap();
    @(posedge I_clka);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge I_clka);
      n++;
    end
    chk("drain_queue_empty", 64'(q.size()), 64'd0);
    repeat (4) @(posedge I_clka);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"},  64'(pif.O_pix_ready), 64'd1);
    chk({tag, "_we"},     64'(O_write_enable), 64'd0);
    chk({tag, "_ada"},    64'(O_ada_flat), 64'd0);
    chk({tag, "_din"},    O_din_flat, 64'd0);
    chk({tag, "_swap"},   64'(O_swap_trigger), 64'd0);
    chk({tag, "_fc"},     64'(O_frame_count), 64'd0);
    chk({tag, "_err"},    64'(O_sof_error), 64'd0);
  endtask

  initial begin
    pif.I_pix_data  = '0;
    pif.I_pix_valid = 1'b0;
    pif.I_pix_sof   = 1'b0;
    I_swap_allow    = 1'b1;
    I_rst_n         = 1'b0;
    repeat (3) @(posedge I_clka);
    #1;
    chk_reset_outputs("reset");
    I_rst_n = 1'b1;
    gap();

    // Frame A, valid every cycle.
    push(K_WE, 2'b00, 64'hA000_0001_A000_0000);
    push(K_WE, 2'b11, 64'hA000_0003_A000_0002);
    push(K_SWAP, 2'b00, 64'd0);
    send(32'hA000_0000, 1'b1);
    send(32'hA000_0001, 1'b0);
    send(32'hA000_0002, 1'b0);
    send(32'hA000_0003, 1'b0);
    drain();
    chk("fc_after_a", 64'(O_frame_count), 64'd1);

    // Frame B, valid toggling.
    push(K_WE, 2'b00, 64'hB000_0001_B000_0000);
    push(K_WE, 2'b11, 64'hB000_0003_B000_0002);
    push(K_SWAP, 2'b00, 64'd0);
    send(32'hB000_0000, 1'b1); gap();
    send(32'hB000_0001, 1'b0); gap();
    send(32'hB000_0002, 1'b0); gap();
    send(32'hB000_0003, 1'b0); gap();
    drain();
    chk("fc_after_b", 64'(O_frame_count), 64'd2);

    // Words without SOF while idle are dropped.
    for (int i = 0; i < 3; i++) push(K_ERR, 2'b00, 64'd0);
    for (int i = 0; i < 3; i++) send(32'hC000_0000 + 32'(i), 1'b0);
    drain();
    chk("fc_after_nosof", 64'(O_frame_count), 64'd2);

    // Early SOF on word 3 restarts the frame.
    push(K_WE, 2'b00, 64'h4000_0001_4000_0000);
    push(K_ERR, 2'b00, 64'd0);
    push(K_WE, 2'b00, 64'h5000_0001_5000_0000);
    push(K_WE, 2'b11, 64'h5000_0003_5000_0002);
    push(K_SWAP, 2'b00, 64'd0);
    send(32'h4000_0000, 1'b1);
    send(32'h4000_0001, 1'b0);
    send(32'h4000_0002, 1'b0);
    send(32'h5000_0000, 1'b1);
    send(32'h5000_0001, 1'b0);
    send(32'h5000_0002, 1'b0);
    send(32'h5000_0003, 1'b0);
    drain();
    chk("fc_after_restart", 64'(O_frame_count), 64'd3);

`ifdef SWAP_GATE_EN
    // Swap held off until the reader allows it.
    I_swap_allow = 1'b0;
    push(K_WE, 2'b00, 64'h6000_0001_6000_0000);
    push(K_WE, 2'b11, 64'h6000_0003_6000_0002);
    push(K_SWAP, 2'b00, 64'd0);
    send(32'h6000_0000, 1'b1);
    send(32'h6000_0001, 1'b0);
    send(32'h6000_0002, 1'b0);
    send(32'h6000_0003, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge I_clka);
      chk("gate_ready_low", 64'(pif.O_pix_ready), 64'd0);
      chk("gate_no_swap", 64'(O_swap_trigger), 64'd0);
    end
    @(posedge I_clka);
    #1;
    I_swap_allow = 1'b1;
    gate_ref_cyc = cyc;
    gate_mode    = 1'b1;
    drain();
    gate_mode = 1'b0;
`endif

    // Reset in the middle of a gather.
    send(32'hD000_0000, 1'b1);
    I_rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    #1;
    I_rst_n = 1'b1;
    exp_fc  = 0;
    gap();
    push(K_WE, 2'b00, 64'hE000_0001_E000_0000);
    push(K_WE, 2'b11, 64'hE000_0003_E000_0002);
    push(K_SWAP, 2'b00, 64'd0);
    send(32'hE000_0000, 1'b1);
    send(32'hE000_0001, 1'b0);
    send(32'hE000_0002, 1'b0);
    send(32'hE000_0003, 1'b0);
    drain();
    chk("fc_after_reset_frame", 64'(O_frame_count), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
